glitch_sequencer: RTL

//  Parametrised successor to the single-shot glitch generators. Sits between the host config regs and the

---
 rtl/glitch_pkg.sv | 21 ++
 rtl/glitch_trig_qual.sv | 55 +++++
 rtl/glitch_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// Shared types and helpers for the glitch sequencer: FSM state encoding,
// edge-select constants and the pattern-index width helper.
package glitch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        HOLDOFF = 3'd2,
        GLITCH  = 3'd3,
        GAP     = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    function automatic int pat_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/glitch_trig_qual.sv
// Trigger qualifier: 2-flop synchroniser, selectable edge detector and a saturating
// edge counter. Everything is held at zero while en is low.
module glitch_trig_qual
    import glitch_pkg::*;
#(
    parameter int PCNT_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              trig_fall,
    input  logic              i_trigger,
    output logic [PCNT_W-1:0] edge_cnt
);

    logic              sync1_q, sync2_q, prev_q;
    logic              edge_s;
    logic [PCNT_W-1:0] cnt_q, cnt_d;

    // Edge detect and saturating count; edge_cnt already includes this cycle's edge.
    always_comb begin
        edge_s = (trig_fall == EDGE_FALL) ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);
        cnt_d  = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (edge_s && (cnt_q != {PCNT_W{1'b1}})) begin
            cnt_d = cnt_q + PCNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign edge_cnt = cnt_d;

    // Synchroniser, edge history and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (!en) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_trigger;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/glitch_sequencer.sv
// Multi-channel glitch sequencer: trigger count, holdoff, repeated pattern plays with gaps.
// Optional watchdog on the trigger wait is enabled with `define GLITCH_TIMEOUT_EN.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int PAT_DEPTH = 32,
    parameter int HOLD_W    = 32,
    parameter int PCNT_W    = 12,
    parameter int REP_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            armed,
    input  logic                            i_trigger,
    input  logic                            trig_fall,
    input  logic                            idle_state,
    input  logic                            on_state,
    input  logic                            rst_on_state,
    input  logic [PCNT_W-1:0]               pulse_target,
    input  logic [HOLD_W-1:0]               holdoff,
    input  logic [HOLD_W-1:0]               gap,
    input  logic [$clog2(PAT_DEPTH+1)-1:0]  pat_len,
    input  logic [REP_W-1:0]                repeats,
    input  logic [CHANNELS*PAT_DEPTH-1:0]   pattern,
`ifdef GLITCH_TIMEOUT_EN
    input  logic [HOLD_W-1:0]               timeout,
    output logic                            timed_out,
`endif
    output logic [CHANNELS-1:0]             out,
    output logic                            tgt_rst,
    output logic                            busy,
    output logic                            rdy
);

    localparam int LEN_W = $clog2(PAT_DEPTH + 1);
    localparam int IDX_W = pat_idx_w(PAT_DEPTH);

    state_e                        state_q, state_d;
    logic                          armed_q, arm_rise_s;
    logic                          trig_fall_q, idle_q, on_q, ros_q;
    logic [PCNT_W-1:0]             tgt_q, edge_cnt_s;
    logic [HOLD_W-1:0]             hold_q, gap_q, cnt_q, cnt_d;
    logic [LEN_W-1:0]              len_q, len_clamp_s, k_q, k_d;
    logic [REP_W-1:0]              rep_cfg_q, rep_cnt_q, rep_cnt_d;
    logic [CHANNELS*PAT_DEPTH-1:0] pat_q;
    logic [IDX_W-1:0]              k_idx_s;
    logic                          idle_s, on_s, ros_s, wd_expired_s;
    logic [CHANNELS-1:0]           out_q, out_d;
    logic                          tgt_rst_q, tgt_rst_d, busy_q, busy_d, rdy_q, rdy_d;

    assign arm_rise_s  = armed & ~armed_q;
    assign len_clamp_s = (pat_len > LEN_W'(PAT_DEPTH)) ? LEN_W'(PAT_DEPTH) : pat_len;
    // Until the snapshot exists (disarmed or arming cycle) the live levels apply.
    assign idle_s  = armed_q ? idle_q : idle_state;
    assign on_s    = armed_q ? on_q   : on_state;
    assign ros_s   = armed_q ? ros_q  : rst_on_state;
    assign k_idx_s = k_d[IDX_W-1:0];

    glitch_trig_qual #(.PCNT_W(PCNT_W)) u_qual (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (armed),
        .trig_fall (trig_fall_q),
        .i_trigger (i_trigger),
        .edge_cnt  (edge_cnt_s)
    );

`ifdef GLITCH_TIMEOUT_EN
    logic [HOLD_W-1:0] timeout_q;
    logic              to_q;
    assign wd_expired_s = (timeout_q != '0) && (cnt_q > timeout_q);
    assign timed_out    = to_q;

    // Watchdog config snapshot and sticky timed-out flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= '0;
            to_q      <= 1'b0;
        end else begin
            if (arm_rise_s) timeout_q <= timeout;
            if (!armed) to_q <= 1'b0;
            else if (state_q == TRIG && state_d == DONE) to_q <= 1'b1;
        end
    end
`else
    assign wd_expired_s = 1'b0;
`endif

    // Config snapshot on the arming cycle; pulse_target 0 behaves as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            trig_fall_q <= 1'b0;
            idle_q      <= 1'b0;
            on_q        <= 1'b0;
            ros_q       <= 1'b0;
            tgt_q       <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            rep_cfg_q   <= '0;
            pat_q       <= '0;
        end else begin
            armed_q <= armed;
            if (arm_rise_s) begin
                trig_fall_q <= trig_fall;
                idle_q      <= idle_state;
                on_q        <= on_state;
                ros_q       <= rst_on_state;
                tgt_q       <= (pulse_target == '0) ? PCNT_W'(1) : pulse_target;
                hold_q      <= holdoff;
                gap_q       <= gap;
                len_q       <= len_clamp_s;
                rep_cfg_q   <= repeats;
                pat_q       <= pattern;
            end
        end
    end

    // Next-state logic; dropping armed aborts from any state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        rep_cnt_d = rep_cnt_q;
        if (!armed) begin
            state_d   = IDLE;
            cnt_d     = '0;
            k_d       = '0;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = TRIG;
                    cnt_d     = '0;
                    k_d       = '0;
                    rep_cnt_d = '0;
                end
                TRIG: begin
                    if (edge_cnt_s == tgt_q) begin
                        state_d = HOLDOFF;
                        cnt_d   = '0;
                    end else if (wd_expired_s) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == hold_q) begin
                        state_d = (len_q == '0) ? DONE : GLITCH;
                        k_d     = '0;
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                GLITCH: begin
                    if (k_q == len_q - LEN_W'(1)) begin
                        state_d = (rep_cnt_q < rep_cfg_q) ? GAP : DONE;
                        cnt_d   = '0;
                    end else begin
                        k_d = k_q + LEN_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == gap_q) begin
                        state_d   = GLITCH;
                        k_d       = '0;
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        out_d     = {CHANNELS{on_s}};
        tgt_rst_d = ~ros_s;
        busy_d    = 1'b0;
        rdy_d     = 1'b0;
        case (state_d)
            IDLE:          out_d = {CHANNELS{idle_s}};
            TRIG, HOLDOFF: busy_d = 1'b1;
            GLITCH: begin
                out_d     = pat_q[int'(k_idx_s)*CHANNELS +: CHANNELS];
                tgt_rst_d = ros_s;
                busy_d    = 1'b1;
            end
            GAP: begin
                tgt_rst_d = ros_s;
                busy_d    = 1'b1;
            end
            DONE: begin
                tgt_rst_d = ros_s;
                rdy_d     = 1'b1;
            end
            default:       out_d = {CHANNELS{idle_s}};
        endcase
    end

    // FSM, sequencing counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            rep_cnt_q <= '0;
            out_q     <= '0;
            tgt_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            rep_cnt_q <= rep_cnt_d;
            out_q     <= out_d;
            tgt_rst_q <= tgt_rst_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
        end
    end

    assign out     = out_q;
    assign tgt_rst = tgt_rst_q;
    assign busy    = busy_q;
    assign rdy     = rdy_q;

endmodule
